// File: rtl/switch_scanner_pkg.sv
// Shared definitions for the switch channel scanner: FSM state encoding,
// dwell counter width helper and output reset constants.
package switch_scanner_pkg;

    // Scanner operating mode
    typedef enum logic [0:0] {
        MANUAL = 1'b0,
        SCAN   = 1'b1
    } scan_state_e;

    // Reset values for the registered LED and CH_IDX outputs
    localparam int LED_RST_VAL = 0;
    localparam int IDX_RST_VAL = 0;

    // Width of a counter that must hold values 0..dwell (at least one bit)
    function automatic int dwell_cnt_w(input int dwell);
        if (dwell < 1) begin
            return 1;
        end
        return (dwell < 2) ? 1 : $clog2(dwell + 1);
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Width-parametrised two-flop synchroniser followed by a stability filter.
// The output takes the synchronised value only after it has been unchanged
// for DB_CYCLES consecutive cycles; the output resets to zero.
module switch_debounce #(
    parameter int W         = 1,
    parameter int DB_CYCLES = 500000
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o
);

    localparam int CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES + 1);
    localparam logic [CW-1:0] DB_LIMIT = CW'(DB_CYCLES);

    logic [W-1:0]  sync1_q, sync2_q;
    logic [W-1:0]  cand_q;
    logic [W-1:0]  out_q, out_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] run;

    // Length of the current unchanged run, including this cycle
    always_comb begin
        run   = (sync2_q == cand_q) ? (cnt_q + CW'(1)) : CW'(1);
        out_d = out_q;
        cnt_d = cnt_q;
        if (sync2_q == out_q) begin
            cnt_d = '0;
        end else if (run >= DB_LIMIT) begin
            out_d = sync2_q;
            cnt_d = '0;
        end else begin
            cnt_d = run;
        end
    end

    // Synchroniser chain, candidate tracker and filter state
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            out_q   <= '0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= din_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
        end
    end

    assign dout_o = out_q;

endmodule

// File: rtl/switch_channel_scanner.sv
// Routes one of N_CH switch channels to the LED bank, either from the
// select switches (manual) or from a dwell-timed auto-scan.
// Optional feature macro: SWITCH_SCANNER_DEBOUNCE_EN (synchronise and
// debounce SEL/AUTO through switch_debounce).
module switch_channel_scanner
    import switch_scanner_pkg::*;
#(
    parameter int CH_W      = 2,
    parameter int N_CH      = 3,
    parameter int SEL_W     = 2,
    parameter int DWELL     = 50000000,
    parameter int DB_CYCLES = 500000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic [N_CH*CH_W-1:0] SW_DATA,
    input  logic [SEL_W-1:0]     SEL,
    input  logic                 AUTO,
    input  logic                 HOLD,
    output logic [CH_W-1:0]      LED,
    output logic [SEL_W-1:0]     CH_IDX,
    output logic                 VALID
);

    localparam int CNT_W  = dwell_cnt_w(DWELL);
    localparam int N_SLOT = 2 ** SEL_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(N_CH - 1);
    localparam logic [SEL_W:0]   N_CH_V   = (SEL_W + 1)'(N_CH);

    // Parameter sanity checks at elaboration
    generate
        if (N_SLOT < N_CH) begin : g_bad_sel_w
            $error("switch_channel_scanner: 2**SEL_W must be >= N_CH");
        end
        if (N_CH < 2) begin : g_bad_n_ch
            $error("switch_channel_scanner: N_CH must be >= 2");
        end
        if (DWELL < 1) begin : g_bad_dwell
            $error("switch_channel_scanner: DWELL must be >= 1");
        end
        if (DB_CYCLES < 1) begin : g_bad_db
            $error("switch_channel_scanner: DB_CYCLES must be >= 1");
        end
    endgenerate

    // Channel slots padded to the full index range; unused slots read zero
    // so an out-of-range manual select naturally drives LED low.
    logic [CH_W-1:0] ch_slots [N_SLOT];

    generate
        for (genvar gi = 0; gi < N_SLOT; gi++) begin : g_slot
            if (gi < N_CH) begin : g_used
                assign ch_slots[gi] = SW_DATA[gi*CH_W +: CH_W];
            end else begin : g_unused
                assign ch_slots[gi] = '0;
            end
        end
    endgenerate

    // Effective (optionally filtered) mode and select inputs
    logic             auto_eff;
    logic [SEL_W-1:0] sel_eff;

`ifdef SWITCH_SCANNER_DEBOUNCE_EN
    logic [SEL_W:0] db_out;

    switch_debounce #(
        .W         (SEL_W + 1),
        .DB_CYCLES (DB_CYCLES)
    ) u_debounce (
        .clk_i  (CLOCK_50),
        .rst_i  (RESET),
        .din_i  ({AUTO, SEL}),
        .dout_o (db_out)
    );

    assign auto_eff = db_out[SEL_W];
    assign sel_eff  = db_out[SEL_W-1:0];
`else
    assign auto_eff = AUTO;
    assign sel_eff  = SEL;
`endif

    logic sel_ok;
    assign sel_ok = ({1'b0, sel_eff} < N_CH_V);

    scan_state_e      state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CH_W-1:0]  led_q, led_d;
    logic             valid_q, valid_d;

    // Next-state: mode transitions, manual select, dwell stepping with HOLD
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        case (state_q)
            MANUAL: begin
                cnt_d = '0;
                if (auto_eff) begin
                    state_d = SCAN;
                    idx_d   = sel_ok ? sel_eff : '0;
                    valid_d = 1'b1;
                end else begin
                    idx_d   = sel_eff;
                    valid_d = sel_ok;
                end
            end
            SCAN: begin
                if (!auto_eff) begin
                    state_d = MANUAL;
                    idx_d   = sel_eff;
                    valid_d = sel_ok;
                    cnt_d   = '0;
                end else begin
                    valid_d = 1'b1;
                    // HOLD freezes both counter and index, even on the advance cycle
                    if (!HOLD) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_d = '0;
                            idx_d = (idx_q == IDX_LAST) ? '0 : (idx_q + SEL_W'(1));
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
            end
            default: begin
                state_d = MANUAL;
                idx_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
        // LED follows the live switches of the index being registered now
        led_d = ch_slots[idx_d];
    end

    // Registered state and outputs, cleared asynchronously by RESET
    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            state_q <= MANUAL;
            idx_q   <= SEL_W'(IDX_RST_VAL);
            cnt_q   <= '0;
            led_q   <= CH_W'(LED_RST_VAL);
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            led_q   <= led_d;
            valid_q <= valid_d;
        end
    end

    assign LED    = led_q;
    assign CH_IDX = idx_q;
    assign VALID  = valid_q;

endmodule
